// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with true fill count, programmable almost flags,
// synchronous flush and sticky errors. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_prog #(
  parameter int D_WIDTH = 48,
  parameter int A_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_wr_en,
  input  logic [D_WIDTH-1:0] i_data,
  input  logic               i_rd_en,
  input  logic [A_WIDTH:0]   i_af_thresh,
  input  logic [A_WIDTH:0]   i_ae_thresh,
  input  logic               i_clr_err,
  output logic [D_WIDTH-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic [A_WIDTH:0]   o_count,
  output logic               o_overflow,
  output logic               o_underflow
);
  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] ONE_C = {{A_WIDTH{1'b0}}, 1'b1};

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               mem_empty;
  logic               wr_acc;
  logic               mem_rd;
  logic               pop;
  logic               wr_rej;
  logic               rd_rej;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);

`ifdef SYNC_FIFO_FWFT_EN
  // Two-stage prefetch: stage A holds the registered RAM read, stage B is the
  // visible head word. A pop refills B from A and A from RAM on the same edge.
  localparam logic [A_WIDTH:0] DEPTH_C = {1'b1, {A_WIDTH{1'b0}}};

  logic               a_valid_q, a_valid_d;
  logic               b_valid_q, b_valid_d;
  logic [D_WIDTH-1:0] a_data_q, a_data_d;
  logic [D_WIDTH-1:0] b_data_q, b_data_d;
  logic               b_free;
  logic               a_free;

  assign o_full  = (count_q == DEPTH_C);
  assign o_empty = ~b_valid_q;
  assign pop     = i_rd_en & b_valid_q & ~i_flush;
  assign b_free  = ~b_valid_q | pop;
  assign a_free  = ~a_valid_q | b_free;
  assign mem_rd  = ~mem_empty & a_free & ~i_flush;
  assign wr_acc  = i_wr_en & ~o_full & ~i_flush;
  assign wr_rej  = i_wr_en & o_full & ~i_flush;
  assign rd_rej  = i_rd_en & ~b_valid_q & ~i_flush;

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (i_flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (b_free) begin
        b_valid_d = a_valid_q;
        if (a_valid_q) b_data_d = a_data_q;
        a_valid_d = 1'b0;
      end
      if (mem_rd) begin
        a_valid_d = 1'b1;
        a_data_d  = mem_q[rd_ptr_q[A_WIDTH-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  assign o_rd_data  = b_data_q;
  assign o_rd_valid = b_valid_q;
`else
  logic               mem_full;
  logic               rd_valid_q, rd_valid_d;
  logic [D_WIDTH-1:0] rd_data_q, rd_data_d;

  assign mem_full = (wr_ptr_q[A_WIDTH-1:0] == rd_ptr_q[A_WIDTH-1:0]) &&
                    (wr_ptr_q[A_WIDTH] != rd_ptr_q[A_WIDTH]);
  assign o_full   = mem_full;
  assign o_empty  = mem_empty;
  assign wr_acc   = i_wr_en & ~mem_full & ~i_flush;
  assign mem_rd   = i_rd_en & ~mem_empty & ~i_flush;
  assign pop      = mem_rd;
  assign wr_rej   = i_wr_en & mem_full & ~i_flush;
  assign rd_rej   = i_rd_en & mem_empty & ~i_flush;

  // o_rd_valid pulses one cycle per accepted read; o_rd_data holds otherwise.
  always_comb begin
    rd_valid_d = mem_rd;
    rd_data_d  = rd_data_q;
    if (mem_rd) rd_data_d = mem_q[rd_ptr_q[A_WIDTH-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_acc ? ONE_C : '0);
    rd_ptr_d = rd_ptr_q + (mem_rd ? ONE_C : '0);
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    // A new error wins over a coincident clear.
    ovf_d = wr_rej | (ovf_q & ~i_clr_err);
    unf_d = rd_rej | (unf_q & ~i_clr_err);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q[A_WIDTH-1:0]] <= i_data;
  end

  assign o_count        = count_q;
  assign o_almost_full  = (count_q >= i_af_thresh);
  assign o_almost_empty = (count_q <= i_ae_thresh);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: randomized traffic against a queue-based reference model.
module tb_sync_fifo_prog;
  localparam int DW    = 48;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wr_en, rd_en, clr_err;
  logic [DW-1:0] wdata;
  logic [AW:0]   af_th, ae_th;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, full, afull, aempty, ovf, unf;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_ovf   = 1'b0;
  logic          exp_unf   = 1'b0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data  = '0;

  sync_fifo_prog #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wr_en(wr_en), .i_data(wdata),
    .i_rd_en(rd_en), .i_af_thresh(af_th), .i_ae_thresh(ae_th), .i_clr_err(clr_err),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_empty(empty), .o_full(full),
    .o_almost_full(afull), .o_almost_empty(aempty), .o_count(count),
    .o_overflow(ovf), .o_underflow(unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Reference model: queue of stored words, updated from the rules at each edge.
  task automatic model_edge();
    bit full_m  = (exp_q.size() == DEPTH);
    bit empty_m = (exp_q.size() == 0);
    if (flush) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = exp_ovf && !clr_err;
      exp_unf   = exp_unf && !clr_err;
    end else begin
      exp_ovf   = (wr_en && full_m) || (exp_ovf && !clr_err);
      exp_unf   = (rd_en && empty_m) || (exp_unf && !clr_err);
      exp_valid = 1'b0;
      if (rd_en && !empty_m) begin
        exp_data  = exp_q.pop_front();
        exp_valid = 1'b1;
      end
      if (wr_en && !full_m) exp_q.push_back(wdata);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    exp_valid = 1'b0;
    exp_data  = '0;
  endtask

  task automatic check_outputs();
    int n = exp_q.size();
    check("count",  count,    n);
    check("empty",  empty,    n == 0);
    check("full",   full,     n == DEPTH);
    check("afull",  afull,    n >= int'(af_th));
    check("aempty", aempty,   n <= int'(ae_th));
    check("ovf",    ovf,      exp_ovf);
    check("unf",    unf,      exp_unf);
    check("rvalid", rd_valid, exp_valid);
    check("rdata",  rd_data,  exp_data);
  endtask

  // driver: inputs change #1 after the edge, outputs sampled there too
  task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rd,
                       input bit fl = 1'b0, input bit clr = 1'b0);
    wr_en = wr; wdata = d; rd_en = rd; flush = fl; clr_err = clr;
    @(posedge clk);
`ifndef SYNC_FIFO_FWFT_EN
    model_edge();
`endif
    #1;
`ifndef SYNC_FIFO_FWFT_EN
    check_outputs();
`endif
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  task automatic run_std();
    int wr_left, rd_left, guard;
    check_outputs();
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, DW'(i), 1'b0);
    check("fill_full", full, 1'b1);
    drive(1'b1, 48'h101, 1'b0);
    check("ovf_257", ovf, 1'b1);
    drive(1'b1, 48'h102, 1'b1);
    check("full_rw_cnt", count, 255);
    check("full_rw_data", rd_data, 48'h1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      check("drain_order", rd_data, DW'(i));
    end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, rand_word(), 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // interleaved bursts across the pointer wrap
    wr_left = 300; rd_left = 300; guard = 0;
    while ((wr_left > 0 || rd_left > 0) && guard < 5000) begin
      int mode = $urandom_range(0, 2);
      int len  = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        bit w = (wr_left > 0) && (mode == 0 || (mode == 2 && $urandom_range(0, 1) == 1));
        bit r = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
        if (w && exp_q.size() < DEPTH) wr_left--;
        if (r && exp_q.size() > 0) rd_left--;
        drive(w, rand_word(), r);
        guard++;
      end
    end
    check("burst_rd_left", rd_left, 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 128; i++) drive(1'b1, rand_word(), 1'b0);
    drive(1'b1, rand_word(), 1'b0, 1'b1);
    check("flush_cnt", count, 0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_word(), 1'b0);
    drive(1'b1, rand_word(), 1'b1, 1'b1);
    check("flush_full_ovf", ovf, 1'b0);

    af_th = 9'd300; ae_th = 9'd400;
    for (int i = 0; i < 4; i++) drive(1'b1, rand_word(), 1'b0);
    af_th = 9'd0; ae_th = 9'd0;
    drive(1'b0, '0, 1'b1);

    for (int p = 0; p < 8; p++) begin
      int bias = $urandom_range(15, 90);
      af_th = 9'($urandom_range(0, 300));
      ae_th = 9'($urandom_range(0, 300));
      for (int k = 0; k < 250; k++) begin
        bit fl  = ($urandom_range(0, 99) == 0);
        bit clr = !fl && ($urandom_range(0, 39) == 0);
        drive($urandom_range(0, 99) < bias, rand_word(),
              $urandom_range(0, 99) < (100 - bias), fl, clr);
      end
    end

    // asynchronous reset between edges, mid-burst
    af_th = 9'd200; ae_th = 9'd4;
    for (int i = 0; i < 20; i++) drive(1'b1, rand_word(), i > 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, rand_word(), 1'b1);
  endtask
`else
  task automatic run_fwft();
    logic [DW-1:0] d;
    int t;
    d = rand_word();
    drive(1'b1, d, 1'b0);
    check("fw_n_valid", rd_valid, 1'b0);
    check("fw_n_count", count, 1);
    drive(1'b0, '0, 1'b0);
    check("fw_n1_valid", rd_valid, 1'b0);
    drive(1'b0, '0, 1'b0);
    check("fw_n2_valid", rd_valid, 1'b1);
    check("fw_n2_data", rd_data, d);
    check("fw_n2_empty", empty, 1'b0);
    drive(1'b0, '0, 1'b1);
    check("fw_pop_valid", rd_valid, 1'b0);
    check("fw_pop_empty", empty, 1'b1);
    check("fw_pop_count", count, 0);
    drive(1'b0, '0, 1'b1);
    check("fw_unf", unf, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("fw_clr", unf, 1'b0);

    for (int i = 0; i < 10; i++) begin
      d = rand_word();
      exp_q.push_back(d);
      drive(1'b1, d, 1'b0);
    end
    check("fw_cnt10", count, 10);
    while (exp_q.size() > 0) begin
      t = 0;
      while (!rd_valid && t < 8) begin
        drive(1'b0, '0, 1'b0);
        t++;
      end
      check("fw_wait_valid", rd_valid, 1'b1);
      check("fw_order", rd_data, exp_q.pop_front());
      drive(1'b0, '0, 1'b1);
    end
    check("fw_drain_empty", empty, 1'b1);
    check("fw_drain_cnt", count, 0);

    for (int i = 0; i < 3; i++) drive(1'b1, rand_word(), 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, rand_word(), 1'b0, 1'b1);
    check("fw_flush_valid", rd_valid, 1'b0);
    check("fw_flush_cnt", count, 0);
    check("fw_flush_ovf", ovf, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    wdata = '0; af_th = 9'd200; ae_th = 9'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_valid", rd_valid, 1'b0);
    rst_n = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    run_fwft();
`else
    run_std();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
